// File: rtl/serial_logic32.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR of two WIDTH-bit operands,
// one CHUNK-bit slice per clock (LSB first), valid/ready in and out.

module serial_logic32_lane (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~(a | b);
    endcase
  end
endmodule

module serial_logic32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [N-1:0][CHUNK-1:0] a;
    logic [N-1:0][CHUNK-1:0] b;
    logic [1:0]              op;
  } req_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  req_t                    req_q;
  logic [N-1:0][CHUNK-1:0] res;
  logic [CHUNK-1:0]        a_sl, b_sl, y_sl;
  logic                    accept;

  // Only the latched operands feed the slice logic, so input churn after
  // acceptance cannot leak into the result.
  assign a_sl = req_q.a[cnt];
  assign b_sl = req_q.b[cnt];

  serial_logic32_lane u_lane [CHUNK-1:0] (
    .op (req_q.op),
    .a  (a_sl),
    .b  (b_sl),
    .y  (y_sl)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      res   <= '0;
      req_q <= '0;
    end else if (accept) begin
      req_q.a  <= a;
      req_q.b  <= b;
      req_q.op <= op;
      res      <= '0;
      cnt      <= '0;
    end else if (state == RUN) begin
      res[cnt] <= y_sl;
      cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign out  = res;
  assign zero = (res == '0);
endmodule

// File: tb/tb_serial_logic32.sv
// Directed + randomized bench for serial_logic32 against a whole-word
// reference of the four logic ops.

module tb_serial_logic32;
  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  a = '0, b = '0;
  logic [1:0]        op = '0;
  logic              in_ready, out_valid, zero;
  logic [WIDTH-1:0]  out;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_logic32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero)
  );

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic [31:0] low_mask(input int nbits);
    logic [31:0] one = 32'h1;
    if (nbits >= 32) return '1;
    return (one << nbits) - 32'h1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble the inputs during RUN, and check the
  // partial results, latency and final result. Leaves the block in DONE.
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb, input logic [1:0] xo);
    logic [31:0] exp;
    int w;
    exp = model(xo, xa, xb);
    a = xa; b = xb; op = xo; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      a = $urandom; b = $urandom; op = 2'($urandom);
      if (k < N) begin
        step();
        check({tag, " partial out"}, out, exp & low_mask(k * CHUNK));
        check({tag, " run handshake"}, {30'd0, in_ready, out_valid}, 32'd0);
      end else begin
        step();
      end
    end
    check({tag, " out_valid at latency N"}, 32'(out_valid), 32'd1);
    check({tag, " in_ready low in DONE"}, 32'(in_ready), 32'd0);
    check({tag, " result"}, out, exp);
    check({tag, " zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, " in_ready after consume"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] exp_q[$];
  int          t_acc[3];

  initial begin
    logic [31:0] ra, rb, hold_out, e;
    logic [1:0]  ro;
    logic        hold_zero, acc;
    int          n_acc, n_res;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out", out, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    step();

    // Basic AND with spec constant
    out_ready = 1'b1;
    run_op("basic and", 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00);
    check("basic and const", out, 32'h0F0F_0000);
    consume("basic and");

    // All ops on one operand pair
    run_op("or", 32'hA5A5_5A5A, 32'h3C3C_C3C3, 2'b01);
    check("or const", out, 32'hBDBD_DBDB);
    consume("or");
    run_op("xor", 32'hA5A5_5A5A, 32'h3C3C_C3C3, 2'b10);
    check("xor const", out, 32'h9999_9999);
    consume("xor");
    run_op("nor", 32'hA5A5_5A5A, 32'h3C3C_C3C3, 2'b11);
    check("nor const", out, 32'h4242_2424);
    consume("nor");
    run_op("and", 32'hA5A5_5A5A, 32'h3C3C_C3C3, 2'b00);
    check("and const", out, 32'h2424_4242);
    consume("and");

    // Zero flag (operands scrambled during RUN by run_op)
    run_op("zero", 32'hAAAA_AAAA, 32'h5555_5555, 2'b00);
    check("zero out const", out, 32'd0);
    check("zero flag const", 32'(zero), 32'd1);
    consume("zero");

    // Back-pressure with a pending input
    out_ready = 1'b0;
    run_op("bp", $urandom, $urandom, 2'($urandom));
    hold_out = out; hold_zero = zero;
    ra = $urandom; rb = $urandom; ro = 2'($urandom);
    a = ra; b = rb; op = ro; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp out stable", out, hold_out);
      check("bp zero stable", 32'(zero), 32'(hold_zero));
      check("bp valid/ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    step();
    check("bp idle after consume", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp pending accepted", 32'(in_ready), 32'd0);
    for (int k = 0; k < N; k++) step();
    check("bp pending valid", 32'(out_valid), 32'd1);
    check("bp pending result", out, model(ro, ra, rb));
    step();

    // Reset in the middle of RUN
    ra = $urandom; rb = $urandom; ro = 2'($urandom);
    a = ra; b = rb; op = ro; in_valid = 1'b1;
    check("mid reset idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mid reset partial", out, model(ro, ra, rb) & low_mask(4 * CHUNK));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out", out, 32'd0);
    run_op("after reset", $urandom, $urandom, 2'($urandom));
    consume("after reset");

    // Random operations
    for (int i = 0; i < 6; i++) begin
      run_op("random", $urandom, $urandom, 2'($urandom));
      consume("random");
    end

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'b1;
    n_acc = 0; n_res = 0;
    for (int c = 0; c < 80 && n_res < 3; c++) begin
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(op, a, b));
        t_acc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("b2b result", out, e);
        n_res++;
      end
      step();
      if (acc) begin
        if (n_acc < 3) begin a = $urandom; b = $urandom; op = 2'($urandom); end
        else in_valid = 1'b0;
      end
    end
    step();
    check("b2b results seen", 32'(n_res), 32'd3);
    check("b2b accept spacing 1", 32'(t_acc[1] - t_acc[0]), 32'(N + 2));
    check("b2b accept spacing 2", 32'(t_acc[2] - t_acc[1]), 32'(N + 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
